fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the program counter and issues word requests to instruction memory.
- Buffers returned words in a small in-order queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects (flushes queued and in-flight words) and halt (stops fetch permanently until reset).

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the PC, issues word requests and queues returned words for decode.
// Ports: clk/rst (async active-high); imem_req_* request channel (valid/ready/addr);
// imem_resp_* in-order response words; inst_* head of the instruction queue toward decode
// (valid/ready/word/pc); redirect_valid/redirect_pc branch redirect; halt_in decoder halt flag
// for the head word; halted reports the terminal HALTED state.
module fetch_unit #(
    parameter int                WIDTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [WIDTH-1:0]  imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WIDTH-1:0]  inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_in,
    output logic              halted
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [WIDTH-1:0]  data_d [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    logic run, fire, keep, pop, halt_ev, redir, flush;

    assign run            = state_q == RUN;
    // Credit check uses only registered counters so the request stays stable until accepted.
    assign imem_req_valid = run && !rst && (({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign inst_valid     = run && cnt_q != '0;
    assign inst           = data_q[rd_q];
    assign inst_pc        = addr_q[rd_q];
    assign halted         = !run;

    always_comb begin
        fire      = imem_req_valid && imem_req_ready;
        keep      = run && imem_resp_valid && disc_q == '0;
        pop       = inst_valid && inst_ready;
        halt_ev   = pop && halt_in;
        redir     = run && redirect_valid && !halt_ev;
        flush     = halt_ev || redir;
        state_d   = halt_ev ? HALTED : state_q;
        pc_d      = redir ? redirect_pc : fire ? pc_q + ADDR_W'(4) : pc_q;
        // resp_pc tracks the address of the next response that will be kept.
        resp_pc_d = redir ? redirect_pc : keep ? resp_pc_q + ADDR_W'(4) : resp_pc_q;
        out_d     = flush ? '0 : out_q + CW'(fire) - CW'(keep);
        // On a flush every request still in flight after this edge becomes a discard.
        disc_d    = flush ? disc_q + out_q + CW'(fire) - CW'(imem_resp_valid)
                          : disc_q - CW'(imem_resp_valid && disc_q != '0);
        cnt_d     = flush ? '0 : cnt_q + CW'(keep) - CW'(pop);
        wr_d      = flush ? '0 : keep ? wr_q + PW'(1) : wr_q;
        rd_d      = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
        data_d    = data_q;
        addr_d    = addr_q;
        if (keep) begin
            data_d[wr_q] = imem_resp_data;
            addr_d[wr_q] = resp_pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            data_q    <= '{default: '0};
            addr_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model and a delivery log.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_in = 1'b0;
    logic        halted;

    fetch_unit #(.WIDTH(32), .ADDR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat = 1;

    // Memory returns ~addr, in order, lat cycles after the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            cyc++;
            if (imem_resp_valid) mq.delete(0);
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= ~mq[0].addr;
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    logic [31:0] log_pc[$];
    logic [31:0] log_d[$];

    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            log_pc.push_back(inst_pc);
            log_d.push_back(inst);
        end
        if (!rst && dut.keep && !dut.pop && dut.cnt_q == DEPTH)
            $error("push into full instruction queue");
    end

    int          errors = 0;
    int          checks = 0;
    int          rd = 0;
    logic [31:0] exp_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain();
        while (rd < log_pc.size()) begin
            chk("deliv_pc", log_pc[rd], exp_pc);
            chk("deliv_data", log_d[rd], ~log_pc[rd]);
            exp_pc += 32'd4;
            rd++;
        end
    endtask

    task automatic wait_first(input logic [31:0] tgt, input string name);
        int snap = log_pc.size();
        int n = 0;
        while (log_pc.size() == snap && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, (log_pc.size() > snap) ? log_pc[snap] : 32'hDEAD_DEAD, tgt);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(inst_valid), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        drain();
        exp_pc = tgt;
        #1;
        chk("redir_inst_valid", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_req_addr, tgt);
    endtask

    typedef struct {
        logic        rr;
        logic        ir;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int snap;
        int n;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;

        for (int i = 0; i < 8; i++) begin
            imem_req_ready = tbl[i].rr;
            inst_ready     = tbl[i].ir;
            #1;
            chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("t%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("t%0d_inst_pc", i), inst_pc, tbl[i].ipc);
                chk($sformatf("t%0d_inst", i), inst, ~tbl[i].ipc);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        drain();

        inst_ready = 1'b0;
        snap = log_pc.size();
        repeat (10) @(negedge clk);
        #1;
        chk("stall_no_deliv", 32'(log_pc.size()), 32'(snap));
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_head_pc", inst_pc, exp_pc);
        inst_ready = 1'b1;
        repeat (10) @(negedge clk);
        drain();
        chk("stall_resumed", 32'(log_pc.size() >= snap + 2), 32'd1);

        lat = 3;
        repeat (10) @(negedge clk);
        drain();
        redirect_to(32'h100);
        wait_first(32'h100, "lat3_first_pc");
        repeat (10) @(negedge clk);
        drain();

        lat = 1;
        repeat (6) @(negedge clk);
        drain();
        n = 0;
        while (!(imem_req_valid && imem_resp_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("same_cycle_found", 32'(imem_req_valid && imem_resp_valid), 32'd1);
        redirect_to(32'h200);
        wait_first(32'h200, "same_cycle_first_pc");
        repeat (6) @(negedge clk);
        drain();

        redirect_to(32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_req_addr", imem_req_addr, 32'h0);
        repeat (8) @(negedge clk);
        drain();

        wait_valid("halt_head_valid");
        halt_in = 1'b1;
        @(negedge clk);
        halt_in = 1'b0;
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        drain();
        snap = log_pc.size();
        for (int k = 0; k < 20; k++) begin
            redirect_valid = (k == 5);
            redirect_pc    = 32'h300;
            @(negedge clk);
            #1;
            chk("halt_hold", {29'd0, imem_req_valid, inst_valid, halted}, 32'd1);
        end
        redirect_valid = 1'b0;
        chk("halt_no_deliv", 32'(log_pc.size()), 32'(snap));
        rst = 1'b1;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
        #1;
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_req_addr", imem_req_addr, 32'h0);
        repeat (8) @(negedge clk);
        drain();

        wait_valid("async_head_valid");
        drain();
        #2;
        rst = 1'b1;
        #1;
        chk("async_outputs", {29'd0, imem_req_valid, inst_valid, halted}, 32'd0);
        chk("async_req_addr", imem_req_addr, 32'h0);
        chk("async_inst", inst, 32'h0);
        chk("async_inst_pc", inst_pc, 32'h0);
        #1;
        rst = 1'b0;
        drain();
        exp_pc = 32'h0;
        repeat (10) @(negedge clk);
        drain();
        chk("async_restart", 32'(rd > 0 && log_pc[log_pc.size() - 1] != 32'h0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
